// File: rtl/ntt_sequencer.sv
// ntt_sequencer: control end of a 256-point Kyber (q=3329) NTT/INTT.
// Runs all 7 layers of a forward (CT) or inverse (GS) transform through a
// single external butterfly.
//
// Each cycle of ISSUE does three things:
//   - presents one coefficient pair address to a 1-cycle-latency RAM;
//   - presents the matching twiddle index to a 1-cycle-latency ROM;
//   - forwards the returned data combinationally to the butterfly.
// The read addresses are delayed to line up with the butterfly's E and O
// outputs, which are then written back in place.
//
// Ports:
//   clk, rst (sync, active-low), start, ct (1=CT NTT, 0=GS INTT)
//   busy, done                     - transform status
//   re, raddr_a/b, rdata_a/b       - coefficient RAM read side
//   tw_addr, tw_data               - twiddle ROM
//   bf_ct, bf_pwm, bf_a/b/w, bf_e/o - butterfly operand/result ports
//   we_e/waddr_e/wdata_e, we_o/waddr_o/wdata_o - RAM write-back ports
module ntt_sequencer #(
  parameter int unsigned LAT_E = 3,
  parameter int unsigned LAT_O = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        ct,
  output logic        busy,
  output logic        done,
  output logic        re,
  output logic [7:0]  raddr_a,
  output logic [7:0]  raddr_b,
  input  logic [11:0] rdata_a,
  input  logic [11:0] rdata_b,
  output logic [6:0]  tw_addr,
  input  logic [11:0] tw_data,
  output logic        bf_ct,
  output logic        bf_pwm,
  output logic [11:0] bf_a,
  output logic [11:0] bf_b,
  output logic [11:0] bf_w,
  input  logic [11:0] bf_e,
  input  logic [11:0] bf_o,
  output logic        we_e,
  output logic [7:0]  waddr_e,
  output logic [11:0] wdata_e,
  output logic        we_o,
  output logic [7:0]  waddr_o,
  output logic [11:0] wdata_o
);

  // Drain length: long enough for the slower butterfly output of the last
  // issue of a layer to be written before the next layer reads.
  localparam int unsigned D  = 1 + ((LAT_E > LAT_O) ? LAT_E : LAT_O);
  localparam int unsigned DE = 1 + LAT_E;
  localparam int unsigned DO = 1 + LAT_O;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  logic [1:0] state_q, state_d;
  logic [6:0] idx_q, idx_d;
  logic [2:0] layer_q, layer_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       mode_q, mode_d;

  logic       issue;
  logic [2:0] lg;
  logic [7:0] len, grp, off, j;
  logic [6:0] tw;

  logic [DE-1:0]      ve_q;
  logic [DE-1:0][7:0] ae_q;
  logic [DO-1:0]      vo_q;
  logic [DO-1:0][7:0] ao_q;

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    layer_d = layer_q;
    dcnt_d  = dcnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = ct;
          idx_d   = '0;
          layer_d = '0;
          dcnt_d  = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        idx_d = idx_q + 7'd1;
        if (idx_q == 7'd127) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (dcnt_q == 8'(D - 1)) begin
          dcnt_d = '0;
          if (layer_q == 3'd6) begin
            state_d = S_FIN;
          end else begin
            layer_d = layer_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else begin
          dcnt_d = dcnt_q + 8'd1;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      layer_q <= '0;
      dcnt_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      layer_q <= layer_d;
      dcnt_q  <= dcnt_d;
      mode_q  <= mode_d;
    end
  end

  assign issue = (state_q == S_ISSUE);
  assign busy  = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done  = (state_q == S_FIN);
  assign re    = issue;

  // ---------------- address generation ----------------
  // lg = log2(len); j = 2*len*g + o is formed as (g << (lg+1)) | o, which
  // is exact because o < len.
  // The 7-bit GS twiddle term wraps 1<<7 to 0, giving 127-g at layer 0.
  always_comb begin
    lg  = mode_q ? (3'd7 - layer_q) : (layer_q + 3'd1);
    len = 8'd1 << lg;
    grp = {1'b0, idx_q} >> lg;
    off = {1'b0, idx_q} & (len - 8'd1);
    j   = (grp << ({1'b0, lg} + 4'd1)) | off;
    if (mode_q) tw = (7'd1 << layer_q) + grp[6:0];
    else        tw = (7'd1 << (3'd7 - layer_q)) - 7'd1 - grp[6:0];
  end

  assign raddr_a = issue ? j         : '0;
  assign raddr_b = issue ? (j + len) : '0;
  assign tw_addr = issue ? tw        : '0;

  // ---------------- operand path ----------------
  assign bf_a   = rdata_a;
  assign bf_b   = rdata_b;
  assign bf_w   = tw_data;
  assign bf_ct  = mode_q;
  assign bf_pwm = 1'b0;

  // ---------------- write-back delay lines ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      ve_q <= '0;
      ae_q <= '0;
      vo_q <= '0;
      ao_q <= '0;
    end else begin
      ve_q[0] <= issue;
      ae_q[0] <= raddr_a;
      for (int unsigned k = 1; k < DE; k++) begin
        ve_q[k] <= ve_q[k-1];
        ae_q[k] <= ae_q[k-1];
      end
      vo_q[0] <= issue;
      ao_q[0] <= raddr_b;
      for (int unsigned k = 1; k < DO; k++) begin
        vo_q[k] <= vo_q[k-1];
        ao_q[k] <= ao_q[k-1];
      end
    end
  end

  assign we_e    = ve_q[DE-1];
  assign waddr_e = ae_q[DE-1];
  assign wdata_e = bf_e;
  assign we_o    = vo_q[DO-1];
  assign waddr_o = ao_q[DO-1];
  assign wdata_o = bf_o;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Bench for ntt_sequencer: behavioural RAM, twiddle ROM and butterfly
// around the sequencer. Checks addresses, write timing, status signals and
// the full forward/inverse transform results.
module tb_ntt_sequencer;
  localparam int Q     = 3329;
  localparam int INV2  = 1665;
  localparam int LAT_E = 3;
  localparam int LAT_O = 4;
  localparam int D     = 5;
  localparam int LSPAN = 128 + D;
  localparam int TDONE = 7 * LSPAN + 1;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0, ct = 1'b0;
  logic        busy, done, re, bf_ct, bf_pwm, we_e, we_o;
  logic [7:0]  raddr_a, raddr_b, waddr_e, waddr_o;
  logic [6:0]  tw_addr;
  logic [11:0] rdata_a, rdata_b, tw_data, bf_a, bf_b, bf_w, bf_e, bf_o;
  logic [11:0] wdata_e, wdata_o;

  ntt_sequencer #(.LAT_E(LAT_E), .LAT_O(LAT_O)) dut (
    .clk(clk), .rst(rst), .start(start), .ct(ct), .busy(busy), .done(done),
    .re(re), .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a),
    .rdata_b(rdata_b), .tw_addr(tw_addr), .tw_data(tw_data), .bf_ct(bf_ct),
    .bf_pwm(bf_pwm), .bf_a(bf_a), .bf_b(bf_b), .bf_w(bf_w), .bf_e(bf_e),
    .bf_o(bf_o), .we_e(we_e), .waddr_e(waddr_e), .wdata_e(wdata_e),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memory and butterfly models ----------------
  logic [11:0] mem [256];
  logic [11:0] zetas [128];
  int          init_mem [256];
  int          gold [256];
  logic        ram_load = 1'b0;

  always @(posedge clk) begin
    if (ram_load) begin
      for (int k = 0; k < 256; k++) mem[k] <= 12'(init_mem[k]);
    end else begin
      if (we_e) mem[waddr_e] <= wdata_e;
      if (we_o) mem[waddr_o] <= wdata_o;
    end
    rdata_a <= mem[raddr_a];
    rdata_b <= mem[raddr_b];
    tw_data <= zetas[tw_addr];
  end

  logic [11:0] pe [LAT_E];
  logic [11:0] po [LAT_O];
  always @(posedge clk) begin
    int a, b, w, t, e, o;
    a = int'(bf_a); b = int'(bf_b); w = int'(bf_w);
    if (bf_ct) begin
      t = (w * b) % Q;
      e = (a + t) % Q;
      o = (a - t + Q) % Q;
    end else begin
      e = ((a + b) * INV2) % Q;
      o = ((((b - a + Q) % Q) * w) % Q * INV2) % Q;
    end
    pe[0] <= 12'(e);
    po[0] <= 12'(o);
    for (int k = 1; k < LAT_E; k++) pe[k] <= pe[k-1];
    for (int k = 1; k < LAT_O; k++) po[k] <= po[k-1];
  end
  assign bf_e = pe[LAT_E-1];
  assign bf_o = po[LAT_O-1];

  function automatic int modpow(input int base, input int ex);
    int r = 1;
    for (int k = 0; k < ex; k++) r = (r * base) % Q;
    return r;
  endfunction

  function automatic int brv7(input int x);
    int r = 0;
    for (int k = 0; k < 7; k++) if (((x >> k) & 1) != 0) r |= 1 << (6 - k);
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct {int c; int a;} wr_t;
  wr_t qe[$], qo[$];
  logic mon_on = 1'b0, mode_exp = 1'b0, run_done = 1'b0;
  int   start_cyc = 0, done_cnt = 0, ecnt = 0, ocnt = 0;

  always @(negedge clk) begin
    int rel, l, i, lg, len, g, o, ja, jb, tw;
    wr_t x;
    if (mon_on) begin
      rel = cyc - start_cyc;
      check("busy_and_done", int'(busy & done), 0);
      if (done) done_cnt++;
      if (rel >= 1 && rel < TDONE) begin
        l = (rel - 1) / LSPAN;
        i = (rel - 1) % LSPAN;
        check("busy_run", busy, 1);
        check("done_early", done, 0);
        if (i < 128) begin
          lg  = mode_exp ? (7 - l) : (l + 1);
          len = 1 << lg;
          g   = i >> lg;
          o   = i & (len - 1);
          ja  = 2 * len * g + o;
          jb  = ja + len;
          tw  = mode_exp ? ((1 << l) + g) : ((1 << (7 - l)) - 1 - g);
          check("re_issue", re, 1);
          check("raddr_a", raddr_a, ja);
          check("raddr_b", raddr_b, jb);
          check("tw_addr", tw_addr, tw);
          check("bf_ct", bf_ct, mode_exp);
          check("bf_pwm", bf_pwm, 0);
          qe.push_back('{cyc + 1 + LAT_E, ja});
          qo.push_back('{cyc + 1 + LAT_O, jb});
        end else begin
          check("re_drain", re, 0);
        end
      end else if (rel == TDONE) begin
        check("done_pulse", done, 1);
        check("busy_at_done", busy, 0);
        check("re_at_done", re, 0);
        run_done = 1'b1;
      end else if (rel > TDONE) begin
        check("busy_after", busy, 0);
        check("done_after", done, 0);
      end

      if (we_e) begin
        ecnt++;
        if (qe.size() == 0) check("we_e_spurious", 1, 0);
        else begin
          x = qe.pop_front();
          check("we_e_cycle", cyc, x.c);
          check("waddr_e", waddr_e, x.a);
        end
      end else if (qe.size() > 0 && qe[0].c <= cyc) begin
        x = qe.pop_front();
        check("we_e_missing", 0, 1);
      end

      if (we_o) begin
        ocnt++;
        if (qo.size() == 0) check("we_o_spurious", 1, 0);
        else begin
          x = qo.pop_front();
          check("we_o_cycle", cyc, x.c);
          check("waddr_o", waddr_o, x.a);
        end
      end else if (qo.size() > 0 && qo[0].c <= cyc) begin
        x = qo.pop_front();
        check("we_o_missing", 0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_checks(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_re"}, re, 0);
    check({tag, "_we_e"}, we_e, 0);
    check({tag, "_we_o"}, we_o, 0);
    check({tag, "_raddr"}, int'({raddr_a, raddr_b}), 0);
    check({tag, "_tw_addr"}, tw_addr, 0);
    check({tag, "_waddr"}, int'({waddr_e, waddr_o}), 0);
  endtask

  task automatic load_ram();
    @(negedge clk); ram_load = 1'b1;
    @(negedge clk); ram_load = 1'b0;
  endtask

  task automatic do_start(input logic mode);
    @(negedge clk);
    start = 1'b1; ct = mode;
    mode_exp = mode; start_cyc = cyc;
    run_done = 1'b0; done_cnt = 0; ecnt = 0; ocnt = 0;
    mon_on = 1'b1;
    @(negedge clk);
    start = 1'b0; ct = ~mode;
  endtask

  task automatic finish_run(input string tag);
    for (int k = 0; k < 1500 && !run_done; k++) @(negedge clk);
    check({tag, "_done_seen"}, run_done, 1);
    repeat (8) @(negedge clk);
    mon_on = 1'b0;
    check({tag, "_done_count"}, done_cnt, 1);
    check({tag, "_e_writes"}, ecnt, 7 * 128);
    check({tag, "_o_writes"}, ocnt, 7 * 128);
    check({tag, "_qe_left"}, qe.size(), 0);
    check({tag, "_qo_left"}, qo.size(), 0);
    qe.delete();
    qo.delete();
  endtask

  initial begin
    int k, zi, z, t;
    for (int n = 0; n < 128; n++) zetas[n] = 12'(modpow(17, brv7(n)));
    for (int n = 0; n < 256; n++) begin
      init_mem[n] = n % Q;
      gold[n] = init_mem[n];
    end
    // Reference Kyber forward NTT.
    zi = 1;
    for (int len = 128; len >= 2; len = len >> 1) begin
      for (int st = 0; st < 256; st += 2 * len) begin
        z = int'(zetas[zi]);
        zi++;
        for (int jj = st; jj < st + len; jj++) begin
          t = (z * gold[jj + len]) % Q;
          gold[jj + len] = (gold[jj] - t + Q) % Q;
          gold[jj] = (gold[jj] + t) % Q;
        end
      end
    end

    // Power-on reset.
    repeat (3) @(negedge clk);
    idle_checks("por");
    rst = 1'b1;
    load_ram();

    // Reset in the middle of ISSUE aborts the transform.
    do_start(1'b1);
    repeat (18) @(negedge clk);
    mon_on = 1'b0;
    rst = 1'b0;
    qe.delete();
    qo.delete();
    for (k = 0; k < 3; k++) begin
      @(negedge clk);
      idle_checks("midrst");
    end
    rst = 1'b1;
    for (k = 0; k < 6; k++) begin
      @(negedge clk);
      idle_checks("postrst");
    end

    // Forward NTT with a stray start (opposite mode) at cycle 50.
    load_ram();
    do_start(1'b1);
    repeat (49) @(negedge clk);
    start = 1'b1; ct = 1'b0;
    @(negedge clk);
    start = 1'b0;
    finish_run("ntt");
    for (int n = 0; n < 256; n++) check("ntt_ram", int'(mem[n]), gold[n]);

    // Inverse on the result restores the original coefficients.
    do_start(1'b0);
    finish_run("intt");
    for (int n = 0; n < 256; n++) check("intt_ram", int'(mem[n]), init_mem[n]);
    idle_checks("end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
